fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, PC value loaded on reset.
REQ-002 Clk  input  1  rising-edge clock for all state.
REQ-003 Rst  input  1  reset, synchronous, active-low.
REQ-004 PC_write  input  1  hazard-unit PC update enable.
REQ-005 IF_write  input  1  hazard-unit IF/ID load enable.
REQ-006 addrSel  input  2  next-PC select: 00 PC+4, 01 jump, 10 branch, 11 jr.
REQ-007 JumpIndex  input  26  J-type instr_index.
REQ-008 BranchTarget  input  32  computed branch target.
REQ-009 JrTarget  input  32  forwarded rs value for jr.
REQ-010 imem_req  output  1  instruction-memory read request, one cycle wide.
REQ-011 imem_addr  output  32  read address, equals PC while imem_req=1.
REQ-012 imem_rdata  input  32  read data, valid when imem_valid=1.
REQ-013 imem_valid  input  1  read response strobe, ≥1 cycle after imem_req.
REQ-014 PC  output  32  current fetch PC.
REQ-015 IFID_Instr  output  32  IF/ID instruction register.
REQ-016 IFID_PCPlus4  output  32  IF/ID PC+4 register.
REQ-017 IFID_Valid  output  1  IF/ID holds a fetched instruction.
REQ-018 fetch_stall  output  1  combinational: no instruction available this cycle.
REQ-019 misalign_err  output  1  sticky misaligned-target flag.

Function
REQ-020 Next PC SHALL be: 00 PC+4; 01 {PC+4[31:28],JumpIndex,2'b00}; 10 BranchTarget; 11 JrTarget; 32-bit wrap-around, no carry out.
REQ-021 FSM states SHALL be REQ, WAIT, HAVE, DISCARD; at most one imem request outstanding.
REQ-022 REQ: imem_req=1, imem_addr=PC; next state WAIT unconditionally.
REQ-023 instr_avail SHALL be 1 in HAVE, or in WAIT with imem_valid=1; fetch_stall = !instr_avail.
REQ-024 When instr_avail=1 and PC_write=1: PC <= next PC; state -> REQ.
REQ-025 When instr_avail=1 and IF_write=1: IFID_Instr <= instruction (imem_rdata in WAIT, buffer in HAVE), IFID_PCPlus4 <= PC+4, IFID_Valid <= 1.
REQ-026 WAIT with imem_valid=1 and PC_write=0: imem_rdata captured into instruction buffer; state -> HAVE.
REQ-027 HAVE with PC_write=0: PC, buffer, state hold.
REQ-028 IF_write=0: IF/ID registers hold regardless of other inputs.
REQ-029 WAIT with imem_valid=0, PC_write=1, addrSel!=00: next PC latched into redirect register; state -> DISCARD; PC unchanged.
REQ-030 WAIT with imem_valid=0 and (PC_write=0 or addrSel=00): PC, IF/ID, state hold.
REQ-031 DISCARD: further redirects (PC_write=1, addrSel!=00) overwrite redirect register; on imem_valid=1 data dropped, PC <= redirect register (or new redirect if same cycle), state -> REQ; IF/ID never loaded in DISCARD.
REQ-032 imem_valid outside WAIT/DISCARD SHALL be ignored.
REQ-033 Minimum throughput SHALL be one instruction per two cycles (REQ+WAIT, 1-cycle memory).

Reset
REQ-034 Rst=0 at a rising edge SHALL set PC=RESET_PC, state=REQ, IFID_Instr=0, IFID_PCPlus4=0, IFID_Valid=0, buffer=0, redirect=0, misalign_err=0, overriding all other inputs.
REQ-035 Reset mid-transaction SHALL abandon the outstanding request; a late imem_valid is ignored until the next REQ-issued request reaches WAIT.
REQ-036 imem_req SHALL be 1 in the first cycle after Rst deasserts.

Configuration
REQ-037 Macro FETCH_MISALIGN_CHECK_EN defined: any PC update whose value has [1:0]!=00 SHALL be suppressed (PC, redirect unchanged, state follows normal path) and misalign_err set to 1 until reset.
REQ-038 Macro undefined: misalign_err SHALL be tied 0 and next-PC bits [1:0] forced to 00.

Verification
REQ-039 Reset, RESET_PC=0x400, 1-cycle memory, PC_write=IF_write=1, addrSel=00 -> imem_addr 0x400,0x404,0x408 on successive REQ cycles; IFID_PCPlus4 0x404,0x408.
REQ-040 PC=0x1000_0010, addrSel=01, JumpIndex=26'h0000040, PC_write=1, IF_write=0 at instr_avail -> PC=0x1000_0100, IF/ID unchanged.
REQ-041 3-cycle memory, branch redirect to 0x2000 in WAIT before imem_valid -> state DISCARD, returned word never in IFID_Instr, next imem_addr=0x2000.
REQ-042 Response arrives with PC_write=IF_write=0 for 4 cycles, then both 1 -> state HAVE, fetch_stall=0 throughout, buffered word loaded into IFID_Instr on release.
REQ-043 With FETCH_MISALIGN_CHECK_EN, addrSel=11, JrTarget=0x0000_3002, PC_write=1 -> PC unchanged, misalign_err=1 until Rst=0; without macro -> PC=0x0000_3000.
REQ-044 Rst=0 asserted while in DISCARD with imem_valid pulsing same cycle -> PC=RESET_PC, IFID_Valid=0, state REQ next cycle.

Source files
------------

// File: rtl/fetch_unit.sv
// fetch_unit: IF stage with a single-outstanding imem request, IF/ID register and redirect tracking.
// Optional build macro FETCH_MISALIGN_CHECK_EN: suppress misaligned PC updates and raise sticky misalign_err.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        PC_write,
    input  logic        IF_write,
    input  logic [1:0]  addrSel,
    input  logic [25:0] JumpIndex,
    input  logic [31:0] BranchTarget,
    input  logic [31:0] JrTarget,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_valid,
    output logic [31:0] PC,
    output logic [31:0] IFID_Instr,
    output logic [31:0] IFID_PCPlus4,
    output logic        IFID_Valid,
    output logic        fetch_stall,
    output logic        misalign_err
);

    localparam int unsigned XLEN = 32;

    typedef enum logic [1:0] {
        S_REQ     = 2'd0,
        S_WAIT    = 2'd1,
        S_HAVE    = 2'd2,
        S_DISCARD = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [XLEN-1:0]   pc_q, pc_d;
    logic [XLEN-1:0]   ibuf_q, ibuf_d;
    logic [XLEN-1:0]   redir_q, redir_d;
    logic [XLEN-1:0]   ifid_instr_q, ifid_instr_d;
    logic [XLEN-1:0]   ifid_pc4_q, ifid_pc4_d;
    logic              ifid_valid_q, ifid_valid_d;
    logic              err_q, err_d;
    logic              imem_req_q, imem_req_d;

    logic [XLEN-1:0]   pc_plus4;
    logic [XLEN-1:0]   npc_raw;
    logic [XLEN-1:0]   npc;
    logic              npc_bad;
    logic              instr_avail;
    logic [XLEN-1:0]   instr_word;
    logic              redirect_req;

    assign pc_plus4 = pc_q + XLEN'(4);

    // Next-PC select; wraps at 32 bits
    always_comb begin
        npc_raw = pc_plus4;
        case (addrSel)
            2'b00:   npc_raw = pc_plus4;
            2'b01:   npc_raw = {pc_plus4[31:28], JumpIndex, 2'b00};
            2'b10:   npc_raw = BranchTarget;
            default: npc_raw = JrTarget;
        endcase
    end

`ifdef FETCH_MISALIGN_CHECK_EN
    assign npc     = npc_raw;
    assign npc_bad = |npc_raw[1:0];
`else
    assign npc     = {npc_raw[XLEN-1:2], 2'b00};
    assign npc_bad = 1'b0;
`endif

    assign instr_avail  = (state_q == S_HAVE) || ((state_q == S_WAIT) && imem_valid);
    assign instr_word   = (state_q == S_WAIT) ? imem_rdata : ibuf_q;
    assign redirect_req = PC_write && (addrSel != 2'b00);

    // Next-state and register-update logic
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        ibuf_d       = ibuf_q;
        redir_d      = redir_q;
        ifid_instr_d = ifid_instr_q;
        ifid_pc4_d   = ifid_pc4_q;
        ifid_valid_d = ifid_valid_q;
        err_d        = err_q;

        case (state_q)
            S_REQ: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (imem_valid) begin
                    if (PC_write) begin
                        state_d = S_REQ;
                        if (npc_bad) err_d = 1'b1;
                        else         pc_d  = npc;
                    end else begin
                        ibuf_d  = imem_rdata;
                        state_d = S_HAVE;
                    end
                end else if (redirect_req) begin
                    // Response still in flight: remember the target and drop the word when it lands
                    state_d = S_DISCARD;
                    if (npc_bad) err_d   = 1'b1;
                    else         redir_d = npc;
                end
            end
            S_HAVE: begin
                if (PC_write) begin
                    state_d = S_REQ;
                    if (npc_bad) err_d = 1'b1;
                    else         pc_d  = npc;
                end
            end
            default: begin
                if (redirect_req) begin
                    if (npc_bad) err_d   = 1'b1;
                    else         redir_d = npc;
                end
                if (imem_valid) begin
                    pc_d    = redir_d;
                    state_d = S_REQ;
                end
            end
        endcase

        if (instr_avail && IF_write) begin
            ifid_instr_d = instr_word;
            ifid_pc4_d   = pc_plus4;
            ifid_valid_d = 1'b1;
        end
    end

    assign imem_req_d = (state_d == S_REQ);

    always_ff @(posedge Clk) begin
        if (!Rst) begin
            state_q      <= S_REQ;
            pc_q         <= RESET_PC;
            ibuf_q       <= '0;
            redir_q      <= '0;
            ifid_instr_q <= '0;
            ifid_pc4_q   <= '0;
            ifid_valid_q <= 1'b0;
            err_q        <= 1'b0;
            imem_req_q   <= 1'b1;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            ibuf_q       <= ibuf_d;
            redir_q      <= redir_d;
            ifid_instr_q <= ifid_instr_d;
            ifid_pc4_q   <= ifid_pc4_d;
            ifid_valid_q <= ifid_valid_d;
            err_q        <= err_d;
            imem_req_q   <= imem_req_d;
        end
    end

    assign imem_req     = imem_req_q;
    assign imem_addr    = pc_q;
    assign PC           = pc_q;
    assign IFID_Instr   = ifid_instr_q;
    assign IFID_PCPlus4 = ifid_pc4_q;
    assign IFID_Valid   = ifid_valid_q;
    assign fetch_stall  = !instr_avail;
    assign misalign_err = err_q;

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: scenario tasks against fetch_unit with a latency-programmable memory model and scoreboards.
module tb_fetch_unit;

    localparam logic [31:0] RST_PC = 32'h0000_0400;

    logic        Clk = 1'b0;
    logic        Rst;
    logic        PC_write, IF_write;
    logic [1:0]  addrSel;
    logic [25:0] JumpIndex;
    logic [31:0] BranchTarget, JrTarget;
    logic        imem_req, imem_valid;
    logic [31:0] imem_addr, imem_rdata;
    logic [31:0] PC, IFID_Instr, IFID_PCPlus4;
    logic        IFID_Valid, fetch_stall, misalign_err;

    int n_cmp = 0;
    int n_err = 0;

    int          mem_lat  = 1;
    int          mem_cnt  = 0;
    logic [31:0] mem_addr = '0;
    bit          force_valid = 1'b0;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc4;
    } ifid_t;

    logic [31:0] q_addr[$];
    ifid_t       q_ifid[$];

    fetch_unit #(.RESET_PC(RST_PC)) dut (
        .Clk(Clk), .Rst(Rst), .PC_write(PC_write), .IF_write(IF_write),
        .addrSel(addrSel), .JumpIndex(JumpIndex), .BranchTarget(BranchTarget),
        .JrTarget(JrTarget), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rdata(imem_rdata), .imem_valid(imem_valid), .PC(PC),
        .IFID_Instr(IFID_Instr), .IFID_PCPlus4(IFID_PCPlus4), .IFID_Valid(IFID_Valid),
        .fetch_stall(fetch_stall), .misalign_err(misalign_err)
    );

    always #5 Clk = ~Clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0] ^ 16'hC3C3, ~a[15:0]};
    endfunction

    // Memory: answers mem_lat cycles after an accepted request, one-cycle valid pulse
    always @(posedge Clk) begin
        if (mem_cnt > 0) mem_cnt <= mem_cnt - 1;
        if (imem_req && Rst) begin
            mem_cnt  <= mem_lat;
            mem_addr <= imem_addr;
        end
    end
    assign imem_valid = force_valid || (mem_cnt == 1);
    assign imem_rdata = force_valid ? 32'hDEAD_BEEF : mem_word(mem_addr);

    task automatic tick;
        @(posedge Clk);
        #1;
    endtask

    task automatic do_reset;
        force_valid = 1'b0;
        PC_write = 1'b0; IF_write = 1'b0; addrSel = 2'b00;
        JumpIndex = '0; BranchTarget = '0; JrTarget = '0;
        q_addr.delete();
        q_ifid.delete();
        Rst = 1'b0;
        tick;
        tick;
        Rst = 1'b1;
    endtask

    task automatic test_reset;
        Rst = 1'b0;
        PC_write = 1'b1; IF_write = 1'b1; addrSel = 2'b11; JrTarget = 32'h0000_7777;
        force_valid = 1'b1;
        tick;
        tick;
        n_cmp++; if (PC !== RST_PC) begin n_err++; $display("FAIL reset_pc: got %h want %h", PC, RST_PC); end
        n_cmp++; if (IFID_Valid !== 1'b0) begin n_err++; $display("FAIL reset_ifid_valid: got %b want 0", IFID_Valid); end
        n_cmp++; if (IFID_Instr !== 32'h0) begin n_err++; $display("FAIL reset_ifid_instr: got %h want 0", IFID_Instr); end
        n_cmp++; if (IFID_PCPlus4 !== 32'h0) begin n_err++; $display("FAIL reset_ifid_pc4: got %h want 0", IFID_PCPlus4); end
        n_cmp++; if (misalign_err !== 1'b0) begin n_err++; $display("FAIL reset_misalign: got %b want 0", misalign_err); end
        Rst = 1'b1; force_valid = 1'b0; PC_write = 1'b0; IF_write = 1'b0; addrSel = 2'b00;
        n_cmp++; if (imem_req !== 1'b1) begin n_err++; $display("FAIL reset_first_req: got %b want 1", imem_req); end
        n_cmp++; if (imem_addr !== RST_PC) begin n_err++; $display("FAIL reset_first_addr: got %h want %h", imem_addr, RST_PC); end
        n_cmp++; if (fetch_stall !== 1'b1) begin n_err++; $display("FAIL reset_stall: got %b want 1", fetch_stall); end
    endtask

    task automatic test_sequential;
        int  k;
        bit  ld;
        ifid_t e;
        logic [31:0] a;
        mem_lat = 1;
        do_reset;
        PC_write = 1'b1; IF_write = 1'b1; addrSel = 2'b00;
        q_addr.push_back(32'h0000_0400);
        q_addr.push_back(32'h0000_0404);
        q_addr.push_back(32'h0000_0408);
        q_ifid.push_back('{mem_word(32'h0000_0400), 32'h0000_0404});
        q_ifid.push_back('{mem_word(32'h0000_0404), 32'h0000_0408});
        k = 0;
        ld = 1'b0;
        for (int cyc = 0; cyc < 20 && (q_addr.size() > 0 || q_ifid.size() > 0); cyc++) begin
            if (ld && q_ifid.size() > 0) begin
                e = q_ifid.pop_front();
                n_cmp++; if (IFID_Instr !== e.instr) begin n_err++; $display("FAIL seq_ifid_instr: got %h want %h", IFID_Instr, e.instr); end
                n_cmp++; if (IFID_PCPlus4 !== e.pc4) begin n_err++; $display("FAIL seq_ifid_pc4: got %h want %h", IFID_PCPlus4, e.pc4); end
                n_cmp++; if (IFID_Valid !== 1'b1) begin n_err++; $display("FAIL seq_ifid_valid: got %b want 1", IFID_Valid); end
            end
            if (imem_req && q_addr.size() > 0) begin
                a = q_addr.pop_front();
                n_cmp++; if (imem_addr !== a) begin n_err++; $display("FAIL seq_addr: got %h want %h", imem_addr, a); end
                n_cmp++; if (cyc !== 2 * k) begin n_err++; $display("FAIL seq_rate: req at cycle %0d want %0d", cyc, 2 * k); end
                k++;
            end
            ld = !fetch_stall && IF_write;
            tick;
        end
        n_cmp++;
        if (q_addr.size() != 0 || q_ifid.size() != 0) begin
            n_err++; $display("FAIL seq_timeout: %0d addr / %0d ifid left, want 0", q_addr.size(), q_ifid.size());
        end
    endtask

    task automatic test_jump;
        mem_lat = 1;
        do_reset;
        PC_write = 1'b1; IF_write = 1'b1; addrSel = 2'b11; JrTarget = 32'h1000_0010;
        tick;
        n_cmp++; if (fetch_stall !== 1'b0) begin n_err++; $display("FAIL jr_avail: stall %b want 0", fetch_stall); end
        tick;
        n_cmp++; if (PC !== 32'h1000_0010) begin n_err++; $display("FAIL jr_pc: got %h want 10000010", PC); end
        addrSel = 2'b01; JumpIndex = 26'h000_0040; IF_write = 1'b0;
        tick;
        tick;
        n_cmp++; if (PC !== 32'h1000_0100) begin n_err++; $display("FAIL jump_pc: got %h want 10000100", PC); end
        n_cmp++; if (IFID_Instr !== mem_word(32'h0000_0400)) begin n_err++; $display("FAIL jump_ifid_hold: got %h want %h", IFID_Instr, mem_word(32'h0000_0400)); end
        n_cmp++; if (IFID_PCPlus4 !== 32'h0000_0404) begin n_err++; $display("FAIL jump_ifid_pc4: got %h want 00000404", IFID_PCPlus4); end
        n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 32'h1000_0100) begin n_err++; $display("FAIL jump_req: req %b addr %h want 1 10000100", imem_req, imem_addr); end
    endtask

    task automatic test_discard;
        bit    ld;
        bit    stale;
        ifid_t e;
        mem_lat = 3;
        do_reset;
        PC_write = 1'b1; IF_write = 1'b1; addrSel = 2'b00;
        tick;
        addrSel = 2'b10; BranchTarget = 32'h0000_2000;
        tick;
        n_cmp++; if (PC !== 32'h0000_0400) begin n_err++; $display("FAIL disc_pc_hold: got %h want 00000400", PC); end
        n_cmp++; if (fetch_stall !== 1'b1) begin n_err++; $display("FAIL disc_stall: got %b want 1", fetch_stall); end
        PC_write = 1'b0; addrSel = 2'b00;
        tick;
        n_cmp++; if (!(imem_valid === 1'b1 && fetch_stall === 1'b1)) begin n_err++; $display("FAIL disc_drop: valid %b stall %b want 1 1", imem_valid, fetch_stall); end
        tick;
        n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 32'h0000_2000) begin n_err++; $display("FAIL disc_redirect: req %b addr %h want 1 00002000", imem_req, imem_addr); end
        n_cmp++; if (IFID_Valid !== 1'b0 || IFID_Instr !== 32'h0) begin n_err++; $display("FAIL disc_ifid: valid %b instr %h want 0 0", IFID_Valid, IFID_Instr); end
        PC_write = 1'b1;
        q_ifid.push_back('{mem_word(32'h0000_2000), 32'h0000_2004});
        ld = 1'b0;
        stale = 1'b0;
        for (int cyc = 0; cyc < 10 && q_ifid.size() > 0; cyc++) begin
            if (IFID_Instr === mem_word(32'h0000_0400)) stale = 1'b1;
            if (ld) begin
                e = q_ifid.pop_front();
                n_cmp++; if (IFID_Instr !== e.instr || IFID_PCPlus4 !== e.pc4) begin n_err++; $display("FAIL disc_refetch: got %h/%h want %h/%h", IFID_Instr, IFID_PCPlus4, e.instr, e.pc4); end
            end else begin
                ld = !fetch_stall && IF_write;
                tick;
            end
        end
        n_cmp++; if (q_ifid.size() != 0 || stale) begin n_err++; $display("FAIL disc_final: left %0d stale %b want 0 0", q_ifid.size(), stale); end
    endtask

    task automatic test_hold;
        ifid_t e;
        mem_lat = 1;
        do_reset;
        PC_write = 1'b0; IF_write = 1'b0; addrSel = 2'b10; BranchTarget = 32'h0000_5000;
        tick;
        for (int c = 0; c < 4; c++) begin
            n_cmp++; if (fetch_stall !== 1'b0) begin n_err++; $display("FAIL hold_stall[%0d]: got %b want 0", c, fetch_stall); end
            n_cmp++; if (PC !== 32'h0000_0400 || imem_req !== 1'b0) begin n_err++; $display("FAIL hold_pc[%0d]: pc %h req %b want 00000400 0", c, PC, imem_req); end
            force_valid = (c == 2);
            tick;
        end
        force_valid = 1'b0;
        n_cmp++; if (IFID_Valid !== 1'b0) begin n_err++; $display("FAIL hold_ifid_valid: got %b want 0", IFID_Valid); end
        PC_write = 1'b1; IF_write = 1'b1; addrSel = 2'b00;
        q_ifid.push_back('{mem_word(32'h0000_0400), 32'h0000_0404});
        q_addr.push_back(32'h0000_0404);
        tick;
        e = q_ifid.pop_front();
        n_cmp++; if (IFID_Instr !== e.instr || IFID_PCPlus4 !== e.pc4 || IFID_Valid !== 1'b1) begin n_err++; $display("FAIL hold_release: got %h/%h/%b want %h/%h/1", IFID_Instr, IFID_PCPlus4, IFID_Valid, e.instr, e.pc4); end
        n_cmp++; if (imem_req !== 1'b1 || imem_addr !== q_addr[0]) begin n_err++; $display("FAIL hold_next_req: req %b addr %h want 1 %h", imem_req, imem_addr, q_addr[0]); end
        void'(q_addr.pop_front());
    endtask

    task automatic test_misalign;
        logic [31:0] exp_pc;
        logic        exp_err;
`ifdef FETCH_MISALIGN_CHECK_EN
        exp_pc  = 32'h0000_0400;
        exp_err = 1'b1;
`else
        exp_pc  = 32'h0000_3000;
        exp_err = 1'b0;
`endif
        mem_lat = 1;
        do_reset;
        PC_write = 1'b1; IF_write = 1'b1; addrSel = 2'b11; JrTarget = 32'h0000_3002;
        tick;
        tick;
        n_cmp++; if (PC !== exp_pc || imem_addr !== exp_pc) begin n_err++; $display("FAIL mis_pc: pc %h addr %h want %h", PC, imem_addr, exp_pc); end
        n_cmp++; if (misalign_err !== exp_err) begin n_err++; $display("FAIL mis_err: got %b want %b", misalign_err, exp_err); end
        addrSel = 2'b00;
        tick;
        tick;
        n_cmp++; if (PC !== exp_pc + 32'd4) begin n_err++; $display("FAIL mis_next_pc: got %h want %h", PC, exp_pc + 32'd4); end
        n_cmp++; if (misalign_err !== exp_err) begin n_err++; $display("FAIL mis_sticky: got %b want %b", misalign_err, exp_err); end
        Rst = 1'b0;
        tick;
        Rst = 1'b1;
        n_cmp++; if (misalign_err !== 1'b0) begin n_err++; $display("FAIL mis_clear: got %b want 0", misalign_err); end
    endtask

    task automatic test_reset_discard;
        bit    ld;
        ifid_t e;
        mem_lat = 3;
        do_reset;
        PC_write = 1'b1; IF_write = 1'b1; addrSel = 2'b00;
        tick;
        addrSel = 2'b10; BranchTarget = 32'h0000_2000;
        tick;
        PC_write = 1'b0; addrSel = 2'b00;
        tick;
        n_cmp++; if (imem_valid !== 1'b1) begin n_err++; $display("FAIL rd_setup: valid %b want 1", imem_valid); end
        Rst = 1'b0; PC_write = 1'b1; addrSel = 2'b10; BranchTarget = 32'h0000_6000;
        tick;
        Rst = 1'b1; addrSel = 2'b00;
        n_cmp++; if (PC !== RST_PC) begin n_err++; $display("FAIL rd_pc: got %h want %h", PC, RST_PC); end
        n_cmp++; if (IFID_Valid !== 1'b0) begin n_err++; $display("FAIL rd_ifid_valid: got %b want 0", IFID_Valid); end
        n_cmp++; if (imem_req !== 1'b1 || imem_addr !== RST_PC) begin n_err++; $display("FAIL rd_req: req %b addr %h want 1 %h", imem_req, imem_addr, RST_PC); end
        q_ifid.push_back('{mem_word(RST_PC), RST_PC + 32'd4});
        ld = 1'b0;
        for (int cyc = 0; cyc < 10 && q_ifid.size() > 0; cyc++) begin
            if (ld) begin
                e = q_ifid.pop_front();
                n_cmp++; if (IFID_Instr !== e.instr || IFID_PCPlus4 !== e.pc4) begin n_err++; $display("FAIL rd_refetch: got %h/%h want %h/%h", IFID_Instr, IFID_PCPlus4, e.instr, e.pc4); end
            end else begin
                ld = !fetch_stall && IF_write;
                tick;
            end
        end
        n_cmp++; if (q_ifid.size() != 0) begin n_err++; $display("FAIL rd_timeout: %0d left want 0", q_ifid.size()); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        Rst = 1'b0;
        PC_write = 1'b0; IF_write = 1'b0; addrSel = 2'b00;
        JumpIndex = '0; BranchTarget = '0; JrTarget = '0;
        test_reset;
        test_sequential;
        test_jump;
        test_discard;
        test_hold;
        test_misalign;
        test_reset_discard;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
